// File: rtl/i2c_master_byte_sequencer.sv
// i2c_master_byte_sequencer
//   Sits between a byte-level command/response stream and the I2C master bit
//   timer. Each accepted command runs exactly one byte on the bus: the
//   sequencer owns the byte shift register, enables the timer for the byte,
//   drives SDA during data bits, and returns one response per command.
//
//   Optional feature (macro I2C_SEQ_ARB_CHECK_EN): during a TX byte, every
//   shift_strobe compares the bus (SDA_sync) with the bit being sent. A
//   released '1' that reads back as '0' means another master won
//   arbitration; the byte ends early with rsp_abort=1 and rsp_arb_lost=1.
//   Without the macro no compare logic exists and rsp_arb_lost is tied 0.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake; cmd_rx, cmd_data, cmd_nack
//   rsp_valid/rsp_ready         response handshake; rsp_data, rsp_ack,
//                               rsp_abort, rsp_timeout, rsp_arb_lost
//   byte_count                  bytes completed without abort/timeout (wraps)
//   timer_active, direction,
//   should_nack                 control to the bit timer
//   shift_strobe, byte_complete,
//   ack, ack_gen, abort         status from the bit timer
//   SDA_sync, SDA_out           synchronised SDA in, open-drain SDA drive out
//
// Parameters
//   BYTE_CNT_W   width of byte_count
//   WDOG_CYCLES  clk cycles allowed in ACTIVE before a timeout (0 = off)

module i2c_master_byte_sequencer #(
  parameter int unsigned BYTE_CNT_W  = 8,
  parameter int unsigned WDOG_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rx,
  input  logic [7:0]            cmd_data,
  input  logic                  cmd_nack,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [7:0]            rsp_data,
  output logic                  rsp_ack,
  output logic                  rsp_abort,
  output logic                  rsp_timeout,
  output logic                  rsp_arb_lost,
  output logic [BYTE_CNT_W-1:0] byte_count,
  output logic                  timer_active,
  output logic                  direction,
  output logic                  should_nack,
  input  logic                  shift_strobe,
  input  logic                  byte_complete,
  input  logic                  ack,
  input  logic                  ack_gen,
  input  logic                  abort,
  input  logic                  SDA_sync,
  output logic                  SDA_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_e;

  // The watchdog counts 0 .. WDOG_CYCLES-1, so it fires on the
  // WDOG_CYCLES-th cycle spent in ACTIVE.
  localparam int unsigned WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST =
    WDOG_W'((WDOG_CYCLES > 0) ? (WDOG_CYCLES - 1) : 0);

  state_e                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    timer_active_q, timer_active_d;
  logic                    direction_q, direction_d;
  logic                    should_nack_q, should_nack_d;
  logic [7:0]              shift_reg_q, shift_reg_d;
  logic [WDOG_W-1:0]       wdog_q, wdog_d;
  logic [BYTE_CNT_W-1:0]   byte_count_q, byte_count_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [7:0]              rsp_data_q, rsp_data_d;
  logic                    rsp_ack_q, rsp_ack_d;
  logic                    rsp_abort_q, rsp_abort_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
`ifdef I2C_SEQ_ARB_CHECK_EN
  logic                    arb_lost_q, arb_lost_d;
`endif

  logic [7:0] shift_next;
  logic       arb_hit;
  logic       wdog_hit;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d        = state_q;
    cmd_ready_d    = cmd_ready_q;
    timer_active_d = timer_active_q;
    direction_d    = direction_q;
    should_nack_d  = should_nack_q;
    shift_reg_d    = shift_reg_q;
    wdog_d         = wdog_q;
    byte_count_d   = byte_count_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    rsp_ack_d      = rsp_ack_q;
    rsp_abort_d    = rsp_abort_q;
    rsp_timeout_d  = rsp_timeout_q;
`ifdef I2C_SEQ_ARB_CHECK_EN
    arb_lost_d     = arb_lost_q;
`endif

    // TX refills with 1s so SDA is released for the slave's ACK slot;
    // RX shifts the bus in MSB-first.
    shift_next = shift_reg_q;
    if (shift_strobe) begin
      shift_next = {shift_reg_q[6:0], direction_q ? SDA_sync : 1'b1};
    end

    arb_hit = 1'b0;
`ifdef I2C_SEQ_ARB_CHECK_EN
    arb_hit = !direction_q && shift_strobe && shift_reg_q[7] && !SDA_sync;
`endif

    wdog_hit = (WDOG_CYCLES != 0) && (wdog_q == WDOG_LAST);

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d        = ACTIVE;
          cmd_ready_d    = 1'b0;
          timer_active_d = 1'b1;
          direction_d    = cmd_rx;
          should_nack_d  = cmd_rx && cmd_nack;
          shift_reg_d    = cmd_rx ? 8'hFF : cmd_data;
          wdog_d         = '0;
        end
      end

      ACTIVE: begin
        shift_reg_d = shift_next;
        wdog_d      = wdog_q + WDOG_W'(1);
        // Priority: timer abort / arbitration loss, then normal completion,
        // then watchdog. The response captures the post-shift register.
        if (abort || arb_hit || byte_complete || wdog_hit) begin
          state_d        = RESP;
          timer_active_d = 1'b0;
          rsp_valid_d    = 1'b1;
          rsp_data_d     = shift_next;
          if (abort || arb_hit) begin
            rsp_abort_d = 1'b1;
`ifdef I2C_SEQ_ARB_CHECK_EN
            arb_lost_d  = arb_hit;
`endif
          end else if (byte_complete) begin
            rsp_ack_d    = direction_q ? !should_nack_q : ack;
            byte_count_d = byte_count_q + BYTE_CNT_W'(1);
          end else begin
            rsp_timeout_d = 1'b1;
          end
        end
      end

      RESP: begin
        // cmd_ready rises only after the handshake edge, so a command can
        // never be taken in the same cycle the response is consumed.
        if (rsp_ready) begin
          state_d       = IDLE;
          cmd_ready_d   = 1'b1;
          rsp_valid_d   = 1'b0;
          rsp_data_d    = 8'h00;
          rsp_ack_d     = 1'b0;
          rsp_abort_d   = 1'b0;
          rsp_timeout_d = 1'b0;
`ifdef I2C_SEQ_ARB_CHECK_EN
          arb_lost_d    = 1'b0;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q        <= IDLE;
      cmd_ready_q    <= 1'b1;
      timer_active_q <= 1'b0;
      direction_q    <= 1'b0;
      should_nack_q  <= 1'b0;
      shift_reg_q    <= 8'hFF;
      wdog_q         <= '0;
      byte_count_q   <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= 8'h00;
      rsp_ack_q      <= 1'b0;
      rsp_abort_q    <= 1'b0;
      rsp_timeout_q  <= 1'b0;
`ifdef I2C_SEQ_ARB_CHECK_EN
      arb_lost_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cmd_ready_q    <= cmd_ready_d;
      timer_active_q <= timer_active_d;
      direction_q    <= direction_d;
      should_nack_q  <= should_nack_d;
      shift_reg_q    <= shift_reg_d;
      wdog_q         <= wdog_d;
      byte_count_q   <= byte_count_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_ack_q      <= rsp_ack_d;
      rsp_abort_q    <= rsp_abort_d;
      rsp_timeout_q  <= rsp_timeout_d;
`ifdef I2C_SEQ_ARB_CHECK_EN
      arb_lost_q     <= arb_lost_d;
`endif
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign timer_active = timer_active_q;
  assign direction    = direction_q;
  assign should_nack  = should_nack_q;
  assign byte_count   = byte_count_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_ack      = rsp_ack_q;
  assign rsp_abort    = rsp_abort_q;
  assign rsp_timeout  = rsp_timeout_q;
`ifdef I2C_SEQ_ARB_CHECK_EN
  assign rsp_arb_lost = arb_lost_q;
`else
  assign rsp_arb_lost = 1'b0;
`endif

  // SDA is released outside ACTIVE. During RX the master only drives the
  // ACK slot, and ack_gen already encodes whether an ACK is wanted there.
  assign SDA_out = (state_q != ACTIVE) ? 1'b1 :
                   direction_q         ? !ack_gen :
                                         shift_reg_q[7];

endmodule

// File: tb/tb_i2c_master_byte_sequencer.sv
// tb_i2c_master_byte_sequencer
//   Directed bench for i2c_master_byte_sequencer. The bench plays the bit
//   timer by hand (strobes, completion, abort), pushes the expected response
//   for every command into a queue, and pops/compares it when the DUT
//   presents rsp_valid. Built with WDOG_CYCLES=50 so the watchdog path is
//   reachable; the arbitration scenario follows I2C_SEQ_ARB_CHECK_EN.

module tb_i2c_master_byte_sequencer;

  localparam int unsigned BYTE_CNT_W  = 8;
  localparam int unsigned WDOG_CYCLES = 50;

  typedef struct packed {
    logic [7:0] data;
    logic       ack;
    logic       abort;
    logic       timeout;
    logic       arb_lost;
  } rsp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_rx;
  logic [7:0]            cmd_data;
  logic                  cmd_nack;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [7:0]            rsp_data;
  logic                  rsp_ack;
  logic                  rsp_abort;
  logic                  rsp_timeout;
  logic                  rsp_arb_lost;
  logic [BYTE_CNT_W-1:0] byte_count;
  logic                  timer_active;
  logic                  direction;
  logic                  should_nack;
  logic                  shift_strobe;
  logic                  byte_complete;
  logic                  ack;
  logic                  ack_gen;
  logic                  abort;
  logic                  SDA_sync;
  logic                  SDA_out;

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];
  int   exp_count = 0;

  i2c_master_byte_sequencer #(
    .BYTE_CNT_W (BYTE_CNT_W),
    .WDOG_CYCLES(WDOG_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rx       (cmd_rx),
    .cmd_data     (cmd_data),
    .cmd_nack     (cmd_nack),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_ack      (rsp_ack),
    .rsp_abort    (rsp_abort),
    .rsp_timeout  (rsp_timeout),
    .rsp_arb_lost (rsp_arb_lost),
    .byte_count   (byte_count),
    .timer_active (timer_active),
    .direction    (direction),
    .should_nack  (should_nack),
    .shift_strobe (shift_strobe),
    .byte_complete(byte_complete),
    .ack          (ack),
    .ack_gen      (ack_gen),
    .abort        (abort),
    .SDA_sync     (SDA_sync),
    .SDA_out      (SDA_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "bench time limit exceeded");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic rx, input logic [7:0] data, input logic nack);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_rx    = rx;
    cmd_data  = data;
    cmd_nack  = nack;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("cmd_ready_wait", 32'd0, 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("timer_active_after_accept", timer_active, 1'b1);
    check("cmd_ready_in_active", cmd_ready, 1'b0);
    check("direction_latched", direction, rx);
  endtask

  task automatic strobe(input logic sda);
    SDA_sync     = sda;
    shift_strobe = 1'b1;
    tick();
    shift_strobe = 1'b0;
    tick();
  endtask

  task automatic pulse_complete(input logic ack_in);
    byte_complete = 1'b1;
    ack           = ack_in;
    tick();
    byte_complete = 1'b0;
    ack           = 1'b0;
    check("timer_active_drop", timer_active, 1'b0);
  endtask

  task automatic get_rsp(input string tag);
    int   n = 0;
    rsp_t e;
    rsp_ready = 1'b1;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_rsp"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rsp_valid"},    rsp_valid,    1'b1);
      check({tag, "_rsp_data"},     rsp_data,     e.data);
      check({tag, "_rsp_ack"},      rsp_ack,      e.ack);
      check({tag, "_rsp_abort"},    rsp_abort,    e.abort);
      check({tag, "_rsp_timeout"},  rsp_timeout,  e.timeout);
      check({tag, "_rsp_arb_lost"}, rsp_arb_lost, e.arb_lost);
    end
    tick();
    rsp_ready = 1'b0;
    check({tag, "_rsp_valid_clear"}, rsp_valid, 1'b0);
    check({tag, "_cmd_ready_back"},  cmd_ready, 1'b1);
    check({tag, "_byte_count"},      byte_count, exp_count[BYTE_CNT_W-1:0]);
  endtask

  initial begin
    logic [7:0] tx;
    logic [7:0] rx_bits;
    int         n;

    rst = 1'b1; cmd_valid = 1'b0; cmd_rx = 1'b0; cmd_data = 8'h00; cmd_nack = 1'b0;
    rsp_ready = 1'b0; shift_strobe = 1'b0; byte_complete = 1'b0; ack = 1'b0;
    ack_gen = 1'b0; abort = 1'b0; SDA_sync = 1'b1;
    repeat (3) tick();
    check("rst_cmd_ready",    cmd_ready,    1'b1);
    check("rst_rsp_valid",    rsp_valid,    1'b0);
    check("rst_byte_count",   byte_count,   '0);
    check("rst_timer_active", timer_active, 1'b0);
    check("rst_direction",    direction,    1'b0);
    check("rst_should_nack",  should_nack,  1'b0);
    check("rst_sda_out",      SDA_out,      1'b1);
    rst = 1'b0;
    tick();

    // 1: TX 0xA5, slave ACKs. SDA follows the byte MSB-first, then releases.
    tx = 8'hA5;
    exp_q.push_back('{data: 8'hFF, ack: 1'b1, abort: 1'b0, timeout: 1'b0, arb_lost: 1'b0});
    exp_count++;
    send_cmd(1'b0, tx, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      check($sformatf("t1_sda_bit%0d", i), SDA_out, tx[i]);
      strobe(tx[i]);
    end
    check("t1_sda_release", SDA_out, 1'b1);
    pulse_complete(1'b1);
    check("t1_sda_after", SDA_out, 1'b1);
    get_rsp("t1");

    // 2: RX, bits 0,1,1,0,1,0,0,1 -> 0x69, ACK generated.
    rx_bits = 8'h69;
    exp_q.push_back('{data: rx_bits, ack: 1'b1, abort: 1'b0, timeout: 1'b0, arb_lost: 1'b0});
    exp_count++;
    send_cmd(1'b1, 8'h00, 1'b0);
    check("t2_should_nack", should_nack, 1'b0);
    for (int i = 7; i >= 0; i--) strobe(rx_bits[i]);
    ack_gen = 1'b1;
    #1 check("t2_sda_ack_slot", SDA_out, 1'b0);
    ack_gen = 1'b0;
    #1 check("t2_sda_released", SDA_out, 1'b1);
    pulse_complete(1'b0);
    get_rsp("t2");

    // 3: RX with NACK; last strobe shares the cycle with byte_complete;
    // response back-pressured for 10 clocks.
    rx_bits = 8'h81;
    exp_q.push_back('{data: rx_bits, ack: 1'b0, abort: 1'b0, timeout: 1'b0, arb_lost: 1'b0});
    exp_count++;
    send_cmd(1'b1, 8'h00, 1'b1);
    check("t3_should_nack", should_nack, 1'b1);
    for (int i = 7; i >= 1; i--) strobe(rx_bits[i]);
    SDA_sync = rx_bits[0]; shift_strobe = 1'b1;
    pulse_complete(1'b1);
    shift_strobe = 1'b0;
    cmd_valid = 1'b1; cmd_rx = 1'b0; cmd_data = 8'h33;
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_rsp_valid", rsp_valid, 1'b1);
      check("t3_hold_rsp_data",  rsp_data,  rx_bits);
      check("t3_hold_rsp_ack",   rsp_ack,   1'b0);
      check("t3_hold_cmd_ready", cmd_ready, 1'b0);
      tick();
    end
    cmd_valid = 1'b0;
    get_rsp("t3");

    // 4a: TX 0x0F aborted after the third strobe -> 0x7F, count unchanged.
    exp_q.push_back('{data: 8'h7F, ack: 1'b0, abort: 1'b1, timeout: 1'b0, arb_lost: 1'b0});
    send_cmd(1'b0, 8'h0F, 1'b0);
    strobe(1'b0); strobe(1'b0); strobe(1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_timer_active_drop", timer_active, 1'b0);
    get_rsp("t4a");

    // 4b: abort and byte_complete in the same clock -> abort wins.
    exp_q.push_back('{data: 8'h3C, ack: 1'b0, abort: 1'b1, timeout: 1'b0, arb_lost: 1'b0});
    send_cmd(1'b0, 8'h3C, 1'b0);
    abort = 1'b1;
    pulse_complete(1'b1);
    abort = 1'b0;
    get_rsp("t4b");

    // 5a: watchdog fires after WDOG_CYCLES clocks in ACTIVE.
    exp_q.push_back('{data: 8'h55, ack: 1'b0, abort: 1'b0, timeout: 1'b1, arb_lost: 1'b0});
    send_cmd(1'b0, 8'h55, 1'b0);
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    check("t5_wdog_cycles", n, WDOG_CYCLES);
    check("t5_timer_active", timer_active, 1'b0);
    get_rsp("t5a");

    // 5b: reset in the middle of a byte.
    send_cmd(1'b1, 8'h00, 1'b1);
    strobe(1'b0); strobe(1'b1);
    rst = 1'b1;
    tick();
    exp_count = 0;
    check("t5_rst_timer_active", timer_active, 1'b0);
    check("t5_rst_cmd_ready",    cmd_ready,    1'b1);
    check("t5_rst_rsp_valid",    rsp_valid,    1'b0);
    check("t5_rst_byte_count",   byte_count,   '0);
    check("t5_rst_direction",    direction,    1'b0);
    check("t5_rst_should_nack",  should_nack,  1'b0);
    check("t5_rst_sda_out",      SDA_out,      1'b1);
    rst = 1'b0;
    tick();

    // 6: TX 0x80 with the bus reading 0 on the first strobe.
    tx = 8'h80;
    send_cmd(1'b0, tx, 1'b0);
`ifdef I2C_SEQ_ARB_CHECK_EN
    exp_q.push_back('{data: 8'h01, ack: 1'b0, abort: 1'b1, timeout: 1'b0, arb_lost: 1'b1});
    strobe(1'b0);
    check("t6_timer_active_drop", timer_active, 1'b0);
`else
    exp_q.push_back('{data: 8'hFF, ack: 1'b1, abort: 1'b0, timeout: 1'b0, arb_lost: 1'b0});
    exp_count++;
    strobe(1'b0);
    for (int i = 6; i >= 0; i--) strobe(tx[i]);
    pulse_complete(1'b1);
`endif
    get_rsp("t6");

    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
